// File: rtl/joy_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : joy_serial_pkg
//  Purpose  : Shared FSM state encoding and width helpers for the serial
//             joystick reader.
//  Revision : 1.0  initial release
// ============================================================================
package joy_serial_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SAMPLE = 3'd2,
    HIGH   = 3'd3,
    LATCH  = 3'd4,
    GAP    = 3'd5
  } state_t;

  // Counter width able to hold 0..n-1; never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/joy_serial_tick.sv
`default_nettype none
// ============================================================================
//  Module   : joy_serial_tick
//  Purpose  : Free-running prescaler; tick is high for one clk_sys cycle
//             out of every DIV cycles.
//  Revision : 1.0  initial release
// ============================================================================
module joy_serial_tick
  import joy_serial_pkg::*;
#(
  parameter int DIV = 24
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic tick
);

  localparam int DIV_W = cnt_width(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] divider;

  // Count 0..DIV-1 and wrap, independent of anything else in the design.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      divider <= '0;
    end else if (divider == DIV_LAST) begin
      divider <= '0;
    end else begin
      divider <= divider + 1'b1;
    end
  end

  assign tick = (divider == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/joy_serial_reader.sv
`default_nettype none
// ============================================================================
//  Module   : joy_serial_reader
//  Purpose  : N-player serial joystick reader for 74HC165-style adapters.
//             Loads the adapter, shifts PLAYERS*BITS_PER_PLAYER bits and
//             latches active-high button words.
//  Config   : JOY_SERIAL_DEBOUNCE_EN - when defined, a new button word is
//             only accepted after two identical consecutive frames.
//  Revision : 1.0  initial release
// ============================================================================
module joy_serial_reader
  import joy_serial_pkg::*;
#(
  parameter int PLAYERS         = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV         = 24,
  parameter int POLL_GAP        = 64
) (
  input  logic                               clk_sys,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               joy_data,
  output logic                               joy_clk,
  output logic                               joy_load,
  output logic [PLAYERS*BITS_PER_PLAYER-1:0] joystick,
  output logic                               frame_valid
);

  localparam int N     = PLAYERS * BITS_PER_PLAYER;
  localparam int BIT_W = cnt_width(N);
  localparam int GAP_W = cnt_width(POLL_GAP);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(POLL_GAP - 1);

  state_t             state;
  logic [BIT_W-1:0]   bitcnt;
  logic [GAP_W-1:0]   gapcnt;
  logic [N-1:0]       raw;
  logic               tick;
  logic               accept;

  joy_serial_tick #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tick    (tick)
  );

`ifdef JOY_SERIAL_DEBOUNCE_EN
  logic [N-1:0] prev;

  // Remember every completed raw frame so the next one can be compared.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else if (state == LATCH) begin
      prev <= raw;
    end
  end

  assign accept = (raw == prev);
`else
  assign accept = 1'b1;
`endif

  // Frame sequencer: load pulse, N shift-clock periods, latch, idle gap.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      joy_clk     <= 1'b0;
      joy_load    <= 1'b1;
      joystick    <= '0;
      frame_valid <= 1'b0;
      bitcnt      <= '0;
      gapcnt      <= '0;
      raw         <= '0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && tick) begin
            state    <= LOAD;
            joy_load <= 1'b0;
          end
        end

        LOAD: begin
          if (!enable) begin
            state    <= IDLE;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
          end else if (tick) begin
            state    <= SAMPLE;
            joy_load <= 1'b1;
            bitcnt   <= '0;
          end
        end

        SAMPLE: begin
          if (!enable) begin
            state    <= IDLE;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
          end else if (tick) begin
            // Data is taken before the rising edge we launch here shifts it.
            for (int k = 0; k < N; k++) begin
              if (bitcnt == BIT_W'(k)) begin
                raw[k] <= ~joy_data;
              end
            end
            joy_clk <= 1'b1;
            state   <= HIGH;
          end
        end

        HIGH: begin
          if (!enable) begin
            state    <= IDLE;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
          end else if (tick) begin
            joy_clk <= 1'b0;
            if (bitcnt == LAST_BIT) begin
              state <= LATCH;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              state  <= SAMPLE;
            end
          end
        end

        LATCH: begin
          if (accept) begin
            joystick <= raw;
          end
          frame_valid <= 1'b1;
          gapcnt      <= '0;
          state       <= GAP;
        end

        GAP: begin
          if (tick) begin
            if (gapcnt == LAST_GAP) begin
              state <= IDLE;
            end else begin
              gapcnt <= gapcnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          joy_clk  <= 1'b0;
          joy_load <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_joy_serial_reader
//  Purpose  : Directed self-checking bench for joy_serial_reader with a
//             behavioural 74HC165 chain model; a second 1x1 instance covers
//             the minimum size configuration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_joy_serial_reader;

  // Adapter load values are active-low; expected words are their inverses.
  localparam logic [23:0] LA = 24'h7FF_FFE;
  localparam logic [23:0] LB = 24'h0F0_5A3;
  localparam logic [23:0] LC = 24'h000_000;
  localparam logic [23:0] JA = 24'h800_001;
  localparam logic [23:0] JB = 24'hF0F_A5C;
  localparam logic [23:0] JC = 24'hFFF_FFF;

`ifdef JOY_SERIAL_DEBOUNCE_EN
  localparam logic [23:0] EXP1 = 24'h0;
  localparam logic [23:0] EXP2 = JA;
  localparam logic [23:0] EXP3 = JA;
  localparam logic [23:0] EXP4 = JB;
  localparam logic [23:0] EXP5 = JB;
`else
  localparam logic [23:0] EXP1 = JA;
  localparam logic [23:0] EXP2 = JA;
  localparam logic [23:0] EXP3 = JB;
  localparam logic [23:0] EXP4 = JB;
  localparam logic [23:0] EXP5 = JC;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [23:0] joystick;
  logic        frame_valid;

  logic        s_en   = 1'b0;
  logic        s_data = 1'b1;
  logic        s_clk;
  logic        s_load;
  logic [0:0]  s_joy;
  logic        s_fv;

  logic [23:0] load_val = LA;
  logic [23:0] sr = '1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  joy_serial_reader #(
    .PLAYERS(2), .BITS_PER_PLAYER(12), .CLK_DIV(4), .POLL_GAP(2)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load), .joystick(joystick), .frame_valid(frame_valid)
  );

  joy_serial_reader #(
    .PLAYERS(1), .BITS_PER_PLAYER(1), .CLK_DIV(2), .POLL_GAP(1)
  ) dut_small (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(s_en), .joy_data(s_data),
    .joy_clk(s_clk), .joy_load(s_load), .joystick(s_joy), .frame_valid(s_fv)
  );

  // 74HC165 chain: async parallel load while SH/LD low, shift on joy_clk rise.
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) sr = load_val;
    else           sr = {1'b1, sr[23:1]};
  end
  assign joy_data = sr[0];

  // Waveform measurements taken between clock edges.
  int  cyc = 0, n_loads = 0, load_fall_cyc = 0, load_period = 0, load_low_len = 0;
  int  clk_rises = 0, rise_cyc = 0, fall_cyc = 0, fv_count = 0, s_rises = 0;
  int  hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
  logic prev_clk = 1'b0, prev_load = 1'b1, s_prev_clk = 1'b0, s_prev_load = 1'b1;

  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    if (prev_load && !joy_load) begin
      n_loads       = n_loads + 1;
      load_period   = cyc - load_fall_cyc;
      load_fall_cyc = cyc;
      clk_rises     = 0;
      hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    end
    if (!prev_load && joy_load) load_low_len = cyc - load_fall_cyc;
    if (!prev_clk && joy_clk) begin
      if (clk_rises > 0) begin
        if (cyc - fall_cyc < lo_min) lo_min = cyc - fall_cyc;
        if (cyc - fall_cyc > lo_max) lo_max = cyc - fall_cyc;
      end
      clk_rises = clk_rises + 1;
      rise_cyc  = cyc;
    end
    if (prev_clk && !joy_clk) begin
      if (cyc - rise_cyc < hi_min) hi_min = cyc - rise_cyc;
      if (cyc - rise_cyc > hi_max) hi_max = cyc - rise_cyc;
      fall_cyc = cyc;
    end
    if (frame_valid) fv_count = fv_count + 1;
    if (s_prev_load && !s_load) s_rises = 0;
    if (!s_prev_clk && s_clk) s_rises = s_rises + 1;
    prev_clk = joy_clk; prev_load = joy_load;
    s_prev_clk = s_clk; s_prev_load = s_load;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_sys); #1;
      if (frame_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_s_fv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys); #1;
      if (s_fv) begin ok = 1'b1; break; end
    end
  endtask

  logic [23:0] lvals [4];
  logic [23:0] exps  [4];

  initial begin : main
    bit ok;
    int fv_before, loads_before;
    lvals = '{LA, LA, LB, LB};
    exps  = '{EXP1, EXP2, EXP3, EXP4};

    // Reset state
    repeat (3) @(negedge clk_sys);
    #1;
    chk("rst_joy_clk", 32'(joy_clk), 32'd0);
    chk("rst_joy_load", 32'(joy_load), 32'd1);
    chk("rst_joystick", 32'(joystick), 32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    reset_n = 1'b1;

    // Four frames: mapping, timing and (optionally) debounce behaviour
    load_val = lvals[0];
    enable   = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_fv(ok);
      chk($sformatf("fv_seen_%0d", f), 32'(ok), 32'd1);
      chk($sformatf("joystick_%0d", f), 32'(joystick), 32'(exps[f]));
      chk($sformatf("rises_%0d", f), 32'(clk_rises), 32'd24);
      if (f == 0) begin
        chk("load_low_len", 32'(load_low_len), 32'd4);
        chk("clk_hi_min", 32'(hi_min), 32'd4);
        chk("clk_hi_max", 32'(hi_max), 32'd4);
        chk("clk_lo_min", 32'(lo_min), 32'd4);
        chk("clk_lo_max", 32'(lo_max), 32'd4);
      end
      if (f == 1) chk("frame_period", 32'(load_period), 32'd208);
      load_val = (f < 3) ? lvals[f+1] : LC;
      @(negedge clk_sys); #1;
      chk($sformatf("fv_width_%0d", f), 32'(frame_valid), 32'd0);
    end

    // Abort after the 10th shift-clock rise
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_sys); #1;
      if (clk_rises == 10) begin ok = 1'b1; break; end
    end
    chk("abort_reach", 32'(ok), 32'd1);
    fv_before    = fv_count;
    enable       = 1'b0;
    @(posedge clk_sys); #1;
    chk("abort_joy_clk", 32'(joy_clk), 32'd0);
    chk("abort_joy_load", 32'(joy_load), 32'd1);
    @(negedge clk_sys); #1;
    loads_before = n_loads;
    repeat (300) @(negedge clk_sys);
    #1;
    chk("abort_no_fv", 32'(fv_count), 32'(fv_before));
    chk("abort_no_load", 32'(n_loads), 32'(loads_before));
    chk("abort_joystick", 32'(joystick), 32'(EXP4));
    chk("idle_joy_clk", 32'(joy_clk), 32'd0);
    chk("idle_joy_load", 32'(joy_load), 32'd1);

    enable = 1'b1;
    wait_fv(ok);
    chk("reen_fv_seen", 32'(ok), 32'd1);
    chk("reen_rises", 32'(clk_rises), 32'd24);
    chk("reen_joystick", 32'(joystick), 32'(EXP5));

    // Asynchronous reset while in SAMPLE
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_sys); #1;
      if (clk_rises == 3 && !joy_clk && joy_load) begin ok = 1'b1; break; end
    end
    chk("mid_reach", 32'(ok), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_joy_clk", 32'(joy_clk), 32'd0);
    chk("mid_rst_joy_load", 32'(joy_load), 32'd1);
    chk("mid_rst_joystick", 32'(joystick), 32'd0);
    chk("mid_rst_fv", 32'(frame_valid), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    enable  = 1'b0;

    // Minimum size: 1 player, 1 bit, CLK_DIV=2
    s_data = 1'b0;
    s_en   = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_s_fv(ok);
      chk($sformatf("small_fv_%0d", f), 32'(ok), 32'd1);
      chk($sformatf("small_rises_%0d", f), 32'(s_rises), 32'd1);
    end
    chk("small_joy_pressed", 32'(s_joy), 32'd1);
    s_data = 1'b1;
    for (int f = 2; f < 4; f++) begin
      wait_s_fv(ok);
      chk($sformatf("small_fv_%0d", f), 32'(ok), 32'd1);
      chk($sformatf("small_rises_%0d", f), 32'(s_rises), 32'd1);
    end
    chk("small_joy_released", 32'(s_joy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
